// File: rtl/tb_err_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_err_collector
// Description : Collects one-cycle error strobes from the pix28 verification
//               checkers into sticky flags, a saturating total count and a
//               first-error record. On request it replays the set indices
//               over a valid/ready stream to the bench reporter.
//               Optional macro TB_ERR_COLLECTOR_TIMESTAMP_EN builds the cycle
//               timestamp counter; without it first_time is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_err_collector #(
    parameter int NUM_IDX = 32,
    parameter int CNT_W   = 16,
    parameter int TS_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IDX-1:0] err_pulse,
    input  logic               clear,
    output logic [NUM_IDX-1:0] err_sticky,
    output logic               err_any,
    output logic [CNT_W-1:0]   err_count,
    output logic               first_valid,
    output logic [4:0]         first_index,
    output logic [TS_W-1:0]    first_time,
    input  logic               report_req,
    output logic               report_busy,
    output logic               report_done,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [4:0]         rpt_index,
    output logic               rpt_last
);

    localparam logic [4:0] LAST_PTR = 5'(NUM_IDX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [4:0]         r_ptr;
    logic [NUM_IDX-1:0] r_shadow;
    logic [TS_W-1:0]    w_ts;
    logic [CNT_W:0]     w_pop;
    logic [CNT_W:0]     w_sum;
    logic [4:0]         w_low;
    logic [NUM_IDX-1:0] w_above_mask;

`ifdef TB_ERR_COLLECTOR_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    // Free-running cycle timestamp, restarted by clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_ts <= '0;
        else if (clear) r_ts <= '0;
        else            r_ts <= r_ts + 1'b1;
    end

    assign w_ts = r_ts;
`else
    assign w_ts = '0;
`endif

    // Popcount of this cycle's pulses and lowest set index
    always_comb begin
        w_pop = '0;
        w_low = '0;
        for (int i = 0; i < NUM_IDX; i++) begin
            w_pop = w_pop + {{CNT_W{1'b0}}, err_pulse[i]};
        end
        for (int i = NUM_IDX - 1; i >= 0; i--) begin
            if (err_pulse[i]) w_low = 5'(i);
        end
    end

    // One spare bit catches overflow so the counter can clamp instead of wrap
    assign w_sum = {1'b0, err_count} + w_pop;

    // Bits strictly above the scan pointer; 2<<31 wraps to 0 giving an empty mask
    assign w_above_mask = ~((NUM_IDX'(2) << r_ptr) - NUM_IDX'(1));

    // Sticky flags, saturating count and first-error capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            err_sticky  <= '0;
            err_any     <= 1'b0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_index <= '0;
            first_time  <= '0;
        end else begin
            err_sticky <= err_sticky | err_pulse;
            err_any    <= |(err_sticky | err_pulse);
            err_count  <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
            if (!first_valid && (|err_pulse)) begin
                first_valid <= 1'b1;
                first_index <= w_low;
                first_time  <= w_ts;
            end
        end
    end

    // Report FSM: walks a snapshot of the sticky flags one index per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_shadow    <= '0;
            report_busy <= 1'b0;
            report_done <= 1'b0;
            rpt_valid   <= 1'b0;
            rpt_index   <= '0;
            rpt_last    <= 1'b0;
        end else begin
            report_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (report_req) begin
                        r_shadow    <= err_sticky;
                        r_ptr       <= '0;
                        r_state     <= S_SCAN;
                        report_busy <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_shadow[r_ptr]) begin
                        r_state   <= S_EMIT;
                        rpt_valid <= 1'b1;
                        rpt_index <= r_ptr;
                        rpt_last  <= ~|(r_shadow & w_above_mask);
                    end else if (r_ptr == LAST_PTR) begin
                        r_state     <= S_DONE;
                        report_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 5'd1;
                    end
                end
                S_EMIT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        if (rpt_last) begin
                            r_state     <= S_DONE;
                            report_done <= 1'b1;
                        end else begin
                            r_ptr   <= r_ptr + 5'd1;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    report_busy <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    report_busy <= 1'b0;
                    rpt_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tb_err_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_tb_err_collector
// Description : Directed self-checking bench for tb_err_collector. A second
//               instance with an 8-bit counter shares the stimulus to
//               exercise count saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tb_err_collector;

`ifdef TB_ERR_COLLECTOR_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] err_pulse = '0;
    logic        clear = 1'b0;
    logic        report_req = 1'b0;
    logic        rpt_ready = 1'b0;

    logic [31:0] err_sticky;
    logic        err_any;
    logic [15:0] err_count;
    logic        first_valid;
    logic [4:0]  first_index;
    logic [31:0] first_time;
    logic        report_busy, report_done, rpt_valid, rpt_last;
    logic [4:0]  rpt_index;

    logic [31:0] sticky8;
    logic        any8;
    logic [7:0]  count8;
    logic        fvalid8;
    logic [4:0]  findex8;
    logic [31:0] ftime8;
    logic        busy8, done8, rvalid8, rlast8;
    logic [4:0]  rindex8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tb_err_collector #(.NUM_IDX(32), .CNT_W(16), .TS_W(32)) u_dut (
        .clk(clk), .reset(reset), .err_pulse(err_pulse), .clear(clear),
        .err_sticky(err_sticky), .err_any(err_any), .err_count(err_count),
        .first_valid(first_valid), .first_index(first_index), .first_time(first_time),
        .report_req(report_req), .report_busy(report_busy), .report_done(report_done),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_index(rpt_index),
        .rpt_last(rpt_last)
    );

    tb_err_collector #(.NUM_IDX(32), .CNT_W(8), .TS_W(32)) u_dut8 (
        .clk(clk), .reset(reset), .err_pulse(err_pulse), .clear(clear),
        .err_sticky(sticky8), .err_any(any8), .err_count(count8),
        .first_valid(fvalid8), .first_index(findex8), .first_time(ftime8),
        .report_req(report_req), .report_busy(busy8), .report_done(done8),
        .rpt_valid(rvalid8), .rpt_ready(rpt_ready), .rpt_index(rindex8),
        .rpt_last(rlast8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          done_cnt;
        int          done_at;
        int          vseen;
        int          stab_err;
        bit          held;
        logic [4:0]  held_idx;
        logic        held_last;
        logic [4:0]  ent_idx[$];
        logic        ent_last[$];
        int          exp8;

        // ---------------- reset state
        repeat (2) tick();
        check("rst_sticky", err_sticky, 0);
        check("rst_any", err_any, 0);
        check("rst_count", err_count, 0);
        check("rst_fvalid", first_valid, 0);
        check("rst_busy", report_busy, 0);
        check("rst_rvalid", rpt_valid, 0);
        check("rst_dut8_outs",
              {sticky8, any8, count8, fvalid8, findex8, busy8, done8, rvalid8, rindex8, rlast8}, 0);
        check("rst_dut8_ftime", ftime8, 0);

        // ---------------- first error at timestamp 5
        reset = 1'b0;
        repeat (5) tick();
        err_pulse = 32'h0000_0008;
        tick();
        err_pulse = '0;
        check("p1_sticky", err_sticky, 32'h8);
        check("p1_count", err_count, 1);
        check("p1_findex", first_index, 3);
        check("p1_ftime", first_time, TS_ON ? 5 : 0);
        check("p1_any", err_any, 1);
        check("p1_fvalid", first_valid, 1);

        // ---------------- multi-bit pulse, later pulse keeps first record
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_sticky", err_sticky, 0);
        check("clr_count", err_count, 0);
        check("clr_fvalid", first_valid, 0);
        err_pulse = 32'h0011_0400; tick();
        check("p2_count", err_count, 3);
        check("p2_findex", first_index, 10);
        err_pulse = 32'h0000_0004; tick();
        err_pulse = '0;
        check("p3_findex", first_index, 10);
        check("p3_count", err_count, 4);
        check("p3_sticky", err_sticky, 32'h0011_0404);

        // ---------------- saturation: all bits every cycle
        clear = 1'b1; tick(); clear = 1'b0;
        err_pulse = 32'hFFFF_FFFF;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp8 = (32 * k > 255) ? 255 : 32 * k;
            check($sformatf("sat16_k%0d", k), err_count, 32 * k);
            check($sformatf("sat8_k%0d", k), count8, exp8);
        end
        err_pulse = '0;

        // ---------------- report with stalls: entries 0, 10, 20
        clear = 1'b1; tick(); clear = 1'b0;
        err_pulse = 32'h0010_0401; tick(); err_pulse = '0;
        report_req = 1'b1; tick(); report_req = 1'b0;
        check("rep_busy_scan0", report_busy, 1);
        check("rep_valid_scan0", rpt_valid, 0);
        done_cnt = 0; stab_err = 0; held = 1'b0; held_idx = '0; held_last = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            rpt_ready = (cyc % 2) == 1;
            err_pulse = (cyc == 2) ? 32'h0000_0020 : 32'h0;
            if (held && (rpt_valid !== 1'b1 || rpt_index !== held_idx || rpt_last !== held_last))
                stab_err++;
            held = 1'b0;
            if (rpt_valid && rpt_ready) begin
                ent_idx.push_back(rpt_index);
                ent_last.push_back(rpt_last);
            end else if (rpt_valid) begin
                held = 1'b1; held_idx = rpt_index; held_last = rpt_last;
            end
            if (report_done) done_cnt++;
            tick();
        end
        rpt_ready = 1'b0; err_pulse = '0;
        check("rep_n_entries", ent_idx.size(), 3);
        if (ent_idx.size() == 3) begin
            check("rep_e0_idx", ent_idx[0], 0);
            check("rep_e1_idx", ent_idx[1], 10);
            check("rep_e2_idx", ent_idx[2], 20);
            check("rep_lasts", {ent_last[0], ent_last[1], ent_last[2]}, 3'b001);
        end
        check("rep_stable", stab_err, 0);
        check("rep_done_cnt", done_cnt, 1);
        check("rep_busy_end", report_busy, 0);
        check("rep_sticky_late", err_sticky, 32'h0010_0421);

        // ---------------- empty report
        clear = 1'b1; tick(); clear = 1'b0;
        report_req = 1'b1; tick(); report_req = 1'b0;
        done_cnt = 0; done_at = 0; vseen = 0;
        for (int k = 1; k <= 40; k++) begin
            if (report_done) begin done_cnt++; done_at = k; end
            if (rpt_valid) vseen++;
            tick();
        end
        check("empty_done_at", done_at, 33);
        check("empty_done_cnt", done_cnt, 1);
        check("empty_no_valid", vseen, 0);

        // ---------------- clear during EMIT
        clear = 1'b1; tick(); clear = 1'b0;
        err_pulse = 32'h0000_0004; tick(); err_pulse = '0;
        report_req = 1'b1; tick(); report_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rpt_valid) break;
            tick();
        end
        check("abort_reach_emit", rpt_valid, 1);
        check("abort_emit_idx", rpt_index, 2);
        clear = 1'b1; err_pulse = 32'h0000_0001; tick();
        clear = 1'b0; err_pulse = '0;
        check("abort_rvalid", rpt_valid, 0);
        check("abort_busy", report_busy, 0);
        check("abort_sticky", err_sticky, 0);
        check("abort_count", err_count, 0);
        check("abort_fvalid", first_valid, 0);
        check("abort_any", err_any, 0);
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (report_done) done_cnt++;
            tick();
        end
        err_pulse = 32'h0000_0002; tick(); err_pulse = '0;
        check("abort_ts_restart", first_time, TS_ON ? 3 : 0);
        check("abort_findex", first_index, 1);
        for (int k = 0; k < 40; k++) begin
            if (report_done) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
